// File: rtl/clock_shift_pkg.sv
// Shared constants for the display shift interface, used by both the
// shift transmitter and the shift_frame_rx receiver.
package clock_shift_pkg;

    localparam int DISPLAY_DIGITS      = 6;
    localparam int SEGS_PER_DIGIT      = 8;
    localparam int SHIFT_WIDTH         = DISPLAY_DIGITS * SEGS_PER_DIGIT;
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage : clock_shift_pkg

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous line, with a registered
// previous sample so a rising edge can be flagged in the i_clk domain.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : sync_edge

// File: rtl/shift_frame_rx.sv
// Serial-to-parallel receiver for the display shift interface: synchronises
// data/clock/latch, shifts bits in and presents only frames of exactly WIDTH bits.
module shift_frame_rx
    import clock_shift_pkg::*;
#(
    parameter int  WIDTH       = SHIFT_WIDTH,
    parameter int  SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int  MSB_FIRST   = 1,
    localparam int CNT_W       = $clog2(WIDTH + 2)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_en,
    input  logic             i_serial_clk,
    input  logic             i_serial_data,
    input  logic             i_serial_latch,
    output logic [WIDTH-1:0] o_parallel_data,
    output logic             o_valid,
    output logic             o_frame_err,
    output logic [CNT_W-1:0] o_bit_count,
    output logic             o_busy
);

    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_OVERRUN = CNT_W'(WIDTH + 1);

    // Holds at WIDTH+1 so an overlong frame can never wrap back to a legal count.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt >= CNT_OVERRUN) ? cnt : cnt + CNT_W'(1);
    endfunction

    logic             data_p0;
    logic             sclk_level_unused;
    logic             latch_level_unused;
    logic             data_rise_unused;
    logic             sclk_rise_p0;
    logic             latch_rise_p0;

    logic [WIDTH-1:0] shift_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic [WIDTH-1:0] shift_next;
    logic [CNT_W-1:0] cnt_next;

    logic [WIDTH-1:0] data_p2;
    logic             vld_p2;
    logic             err_p2;

    // Stage p0: all three lines share one synchroniser depth so they stay aligned.
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk      (i_clk),
        .reset_n  (i_reset_n),
        .async_in (i_serial_clk),
        .level    (sclk_level_unused),
        .rise     (sclk_rise_p0)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
        .clk      (i_clk),
        .reset_n  (i_reset_n),
        .async_in (i_serial_latch),
        .level    (latch_level_unused),
        .rise     (latch_rise_p0)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
        .clk      (i_clk),
        .reset_n  (i_reset_n),
        .async_in (i_serial_data),
        .level    (data_p0),
        .rise     (data_rise_unused)
    );

    // Stage p1: a same-cycle shift is applied before the latch looks at the frame.
    always_comb begin
        shift_next = shift_p1;
        cnt_next   = cnt_p1;
        if (sclk_rise_p0) begin
            if (MSB_FIRST != 0) begin
                shift_next = {shift_p1[WIDTH-2:0], data_p0};
            end else begin
                shift_next = {data_p0, shift_p1[WIDTH-1:1]};
            end
            cnt_next = sat_inc(cnt_p1);
        end
    end

    // Stage p2: frame-length check at the latch edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            shift_p1 <= '0;
            cnt_p1   <= '0;
            data_p2  <= '0;
            vld_p2   <= 1'b0;
            err_p2   <= 1'b0;
        end else begin
            vld_p2 <= 1'b0;
            if (!i_en) begin
                cnt_p1 <= '0;
            end else begin
                shift_p1 <= shift_next;
                if (latch_rise_p0) begin
                    cnt_p1 <= '0;
                    if (cnt_next == CNT_FULL) begin
                        data_p2 <= shift_next;
                        vld_p2  <= 1'b1;
                        err_p2  <= 1'b0;
                    end else begin
                        err_p2  <= 1'b1;
                    end
                end else begin
                    cnt_p1 <= cnt_next;
                end
            end
        end
    end

    assign o_parallel_data = data_p2;
    assign o_valid         = vld_p2;
    assign o_frame_err     = err_p2;
    assign o_bit_count     = cnt_p1;
    assign o_busy          = (cnt_p1 != '0);

endmodule : shift_frame_rx

// File: tb/tb_shift_frame_rx.sv
// Randomised bench for shift_frame_rx: MSB-first and LSB-first instances share
// stimulus and are compared against a bit-queue frame model.
module tb_shift_frame_rx;

    localparam int W     = 48;
    localparam int CW    = $clog2(W + 2);
    localparam int SYNC  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          sclk = 1'b0;
    logic          sd = 1'b0;
    logic          latch = 1'b0;

    logic [W-1:0]  data_m, data_l;
    logic          vld_m, vld_l, err_m, err_l, busy_m, busy_l;
    logic [CW-1:0] cnt_m, cnt_l;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            vcnt_m  = 0;
    int            vcnt_l  = 0;
    int            good_frames = 0;

    bit            q[$];
    logic [W-1:0]  exp_m = '0;
    logic [W-1:0]  exp_l = '0;
    logic          exp_err = 1'b0;

    always #10 clk = ~clk;

    shift_frame_rx #(.WIDTH(W), .SYNC_STAGES(SYNC), .MSB_FIRST(1)) dut_m (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_serial_clk(sclk),
        .i_serial_data(sd), .i_serial_latch(latch), .o_parallel_data(data_m),
        .o_valid(vld_m), .o_frame_err(err_m), .o_bit_count(cnt_m), .o_busy(busy_m)
    );

    shift_frame_rx #(.WIDTH(W), .SYNC_STAGES(SYNC), .MSB_FIRST(0)) dut_l (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_serial_clk(sclk),
        .i_serial_data(sd), .i_serial_latch(latch), .o_parallel_data(data_l),
        .o_valid(vld_l), .o_frame_err(err_l), .o_bit_count(cnt_l), .o_busy(busy_l)
    );

    always @(posedge clk) begin
        if (vld_m === 1'b1) vcnt_m++;
        if (vld_l === 1'b1) vcnt_l++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic int exp_count();
        if (!en) return 0;
        return (q.size() > W + 1) ? W + 1 : q.size();
    endfunction

    task automatic check_idle_state(input string tag);
        check({tag, "_data_m"}, data_m, exp_m);
        check({tag, "_data_l"}, data_l, exp_l);
        check({tag, "_err_m"}, err_m, exp_err);
        check({tag, "_err_l"}, err_l, exp_err);
        check({tag, "_cnt_m"}, cnt_m, exp_count());
        check({tag, "_cnt_l"}, cnt_l, exp_count());
        check({tag, "_busy_m"}, busy_m, exp_count() != 0);
    endtask

    task automatic present_bit(input bit b, input int half);
        @(negedge clk);
        sd = b;
        repeat (half - 1) @(negedge clk);
    endtask

    task automatic send_bit(input bit b, input int half);
        present_bit(b, half);
        sclk = 1'b1;
        if (en) q.push_back(b);
        repeat (half) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input int half);
        for (int i = 0; i < W; i++) send_bit(w[W-1-i], half);
    endtask

    task automatic send_random(input int n, input int half);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)), half);
    endtask

    // Raises the latch (optionally together with a serial clock edge whose bit
    // the caller has already queued) and checks the whole frame outcome.
    task automatic pulse_latch(input string tag, input bit with_sclk);
        bit           good;
        logic [W-1:0] fm, fl;
        @(negedge clk);
        if (with_sclk) sclk = 1'b1;
        latch = 1'b1;
        good = en && (q.size() == W);
        fm = '0;
        fl = '0;
        if (good) begin
            for (int i = 0; i < W; i++) begin
                fm = fm * 2 + W'(q[i]);
                fl[i] = q[i];
            end
        end
        for (int k = 1; k <= SYNC + 2; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_vld_m_c%0d", tag, k), vld_m, good && (k == SYNC + 1));
            check($sformatf("%s_vld_l_c%0d", tag, k), vld_l, good && (k == SYNC + 1));
        end
        @(negedge clk);
        latch = 1'b0;
        sclk  = 1'b0;
        if (en) begin
            if (good) begin
                exp_m = fm;
                exp_l = fl;
                good_frames++;
            end
            exp_err = !good;
            q.delete();
        end
        repeat (3) @(negedge clk);
        check_idle_state(tag);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_idle_state("reset");
        check("reset_vld", vld_m, 1'b0);
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (3) @(negedge clk);

        // 1 MHz serial clock, known word
        send_word(48'hA53C0FF01234, 25);
        check_idle_state("s1_pre");
        pulse_latch("s1", 1'b0);
        check("s1_word_m", data_m, 48'hA53C0FF01234);
        check("s1_word_l", data_l, 48'h2C480FF03CA5);

        // short frame then a good one
        send_random(47, 3);
        check_idle_state("s2_pre");
        pulse_latch("s2_short", 1'b0);
        check("s2_hold", data_m, 48'hA53C0FF01234);
        send_word(48'h123456789ABC, 3);
        pulse_latch("s2_good", 1'b0);
        check("s2_word", data_m, 48'h123456789ABC);

        // overrun
        send_random(50, 3);
        check("s3_sat", cnt_m, 49);
        pulse_latch("s3", 1'b0);

        // 48th serial edge coincides with the latch edge
        send_random(47, 3);
        begin
            bit b;
            b = 1'($urandom_range(0, 1));
            present_bit(b, 3);
            q.push_back(b);
        end
        pulse_latch("s4", 1'b1);

        // disabled: whole frame ignored
        en = 1'b0;
        send_random(48, 3);
        check_idle_state("s5_dis");
        pulse_latch("s5_dis", 1'b0);
        @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        en = 1'b1;
        repeat (4) @(negedge clk);
        check("s5_reen_cnt", cnt_m, 0);
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        send_random(48, 3);
        pulse_latch("s5_reen", 1'b0);

        // reset mid-frame
        send_random(20, 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        q.delete();
        exp_m = '0;
        exp_l = '0;
        exp_err = 1'b0;
        check_idle_state("s6_rst");
        check("s6_rst_vld", vld_m, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_random(48, 3);
        pulse_latch("s6", 1'b0);

        // randomised frames
        for (int f = 0; f < 10; f++) begin
            int n;
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 52)) : W;
            send_random(n, int'($urandom_range(3, 4)));
            pulse_latch($sformatf("rnd%0d", f), 1'b0);
        end

        check("total_vld_m", vcnt_m, good_frames);
        check("total_vld_l", vcnt_l, good_frames);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_shift_frame_rx
